uart_matrix_loader: RTL and testbench



---
 rtl/uart_matrix_loader.sv | 167 ++++++++++++++++
 tb/tb_uart_matrix_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_matrix_loader.sv
// UART 8N1 receiver with sync-byte packet framing.
// Delivers N_BYTES payload bytes as a flat array over valid/ready.
module uart_matrix_loader #(
  parameter int         CLKS_PER_BIT = 87,
  parameter int         N_BYTES      = 8,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RXD,
  output logic [8*N_BYTES-1:0] arr_data,
  output logic                 arr_valid,
  input  logic                 arr_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST = IW'(N_BYTES - 1);

  typedef enum logic [1:0] {
    B_IDLE, B_START, B_DATA, B_STOP
  } bit_t;

  typedef enum logic [1:0] {
    P_HUNT, P_LOAD, P_DONE
  } pkt_t;

  logic          rx_meta, rx;
  bit_t          bstate, bnext;
  logic [CW-1:0] cnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic          byte_done;
  logic          clr_cnt, shift, done_set, err_set;

  pkt_t          pstate, pnext;
  logic [IW-1:0] idx;
  logic          wr, idx_clr, idx_inc, ov_set, sync_hit;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rx      <= rx_meta;
    end
  end

  always_comb begin
    bnext    = bstate;
    clr_cnt  = 1'b0;
    shift    = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    unique case (bstate)
      B_IDLE: begin
        if (!rx) begin
          bnext   = B_START;
          clr_cnt = 1'b1;
        end
      end
      B_START: begin
        if (cnt == HALF) begin
          clr_cnt = 1'b1;
          bnext   = rx ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (cnt == FULL) begin
          clr_cnt = 1'b1;
          shift   = 1'b1;
          if (bidx == 3'd7) bnext = B_STOP;
        end
      end
      B_STOP: begin
        if (cnt == FULL) begin
          clr_cnt  = 1'b1;
          bnext    = B_IDLE;
          done_set = rx;
          err_set  = !rx;
        end
      end
      default: bnext = B_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bstate    <= B_IDLE;
      cnt       <= '0;
      bidx      <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      bstate    <= bnext;
      byte_done <= done_set;
      frame_err <= err_set;
      if (bstate == B_IDLE || clr_cnt) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (bstate != B_DATA) bidx <= '0;
      else if (shift) bidx <= bidx + 1'b1;
      if (shift) shreg <= {rx, shreg[7:1]};
    end
  end

  assign arr_valid = (pstate == P_DONE);
  assign busy      = (pstate == P_LOAD);
  assign sync_hit  = byte_done && (shreg == SYNC_BYTE);

  always_comb begin
    pnext   = pstate;
    wr      = 1'b0;
    idx_clr = 1'b0;
    idx_inc = 1'b0;
    ov_set  = 1'b0;
    unique case (pstate)
      P_HUNT: begin
        if (sync_hit) begin
          pnext   = P_LOAD;
          idx_clr = 1'b1;
        end
      end
      P_LOAD: begin
        if (frame_err) begin
          pnext = P_HUNT;
        end else if (byte_done) begin
          wr = 1'b1;
          if (idx == LAST) pnext = P_DONE;
          else idx_inc = 1'b1;
        end
      end
      P_DONE: begin
        // a byte landing on the handshake cycle is judged as a HUNT byte
        if (arr_ready) begin
          pnext   = sync_hit ? P_LOAD : P_HUNT;
          idx_clr = 1'b1;
        end else if (byte_done) begin
          ov_set = 1'b1;
        end
      end
      default: pnext = P_HUNT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pstate   <= P_HUNT;
      idx      <= '0;
      arr_data <= '0;
      overrun  <= 1'b0;
    end else begin
      pstate  <= pnext;
      overrun <= ov_set;
      if (idx_clr) idx <= '0;
      else if (idx_inc) idx <= idx + 1'b1;
      if (wr) arr_data[idx*8 +: 8] <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Bench for uart_matrix_loader: directed packets plus a random
// byte stream checked against a packet-level reference model.
module tb_uart_matrix_loader;

  localparam int CPB = 4;
  localparam int NB  = 2;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          RXD;
  logic [15:0]   arr_data;
  logic          arr_valid;
  logic          arr_ready;
  logic          busy;
  logic          frame_err;
  logic          overrun;

  uart_matrix_loader #(
    .CLKS_PER_BIT(CPB),
    .N_BYTES     (NB),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .RXD      (RXD),
    .arr_data (arr_data),
    .arr_valid(arr_valid),
    .arr_ready(arr_ready),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // observed side
  logic [15:0] got[$];
  int n_valid = 0;
  int n_fe = 0;
  int n_ov = 0;

  always @(negedge CLK) begin
    if (arr_valid) n_valid++;
    if (arr_valid && arr_ready) got.push_back(arr_data);
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
  end

  // reference model: packet framing from byte stream, consumer always ready
  logic [15:0] exp_q[$];
  logic [7:0]  m_buf[NB];
  bit          m_load = 0;
  int          m_idx = 0;
  int          m_fe = 0;
  int          rd = 0;

  task automatic model(input logic [7:0] b, input bit ok);
    logic [15:0] p;
    if (!ok) begin
      m_fe++;
      m_load = 0;
    end else if (!m_load) begin
      if (b == SYNC) begin
        m_load = 1;
        m_idx  = 0;
      end
    end else begin
      m_buf[m_idx] = b;
      if (m_idx == NB - 1) begin
        p = {m_buf[1], m_buf[0]};
        exp_q.push_back(p);
        m_load = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    RXD = v;
    cyc(CPB);
  endtask

  task automatic send(input logic [7:0] b, input bit ok = 1);
    model(b, ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(ok);
    RXD = 1'b1;
    cyc(2 * CPB);
  endtask

  task automatic check_pkts(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = rd; i < got.size() && i < exp_q.size(); i++)
      chk({tag, "_data"}, got[i], exp_q[i]);
    rd = got.size();
  endtask

  function automatic logic [15:0] last_got();
    if (got.size() == 0) return 16'hxxxx;
    return got[got.size() - 1];
  endfunction

  int v0, fe0, ov0;

  task automatic snap();
    v0  = n_valid;
    fe0 = n_fe;
    ov0 = n_ov;
  endtask

  initial begin
    RESET = 1'b0;
    RXD = 1'b1;
    arr_ready = 1'b1;
    cyc(3);
    chk("rst_valid", arr_valid, 0);
    chk("rst_data", arr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ov", overrun, 0);
    RESET = 1'b1;
    cyc(4);

    // basic packet
    snap();
    send(8'hA5);
    chk("t1_busy_a5", busy, 1);
    send(8'h3C);
    chk("t1_busy_3c", busy, 1);
    send(8'hC3);
    chk("t1_busy_end", busy, 0);
    chk("t1_nvalid", n_valid - v0, 1);
    chk("t1_last", last_got(), 16'hC33C);
    chk("t1_flags", (n_fe - fe0) + (n_ov - ov0), 0);
    check_pkts("t1");

    // leading junk before sync
    snap();
    send(8'h11);
    send(8'h22);
    chk("t2_busy_junk", busy, 0);
    send(8'hA5);
    send(8'h01);
    send(8'h02);
    chk("t2_nvalid", n_valid - v0, 1);
    chk("t2_last", last_got(), 16'h0201);
    check_pkts("t2");

    // framing error aborts packet
    snap();
    send(8'hA5);
    send(8'h01);
    send(8'h02, 0);
    chk("t3_busy_abort", busy, 0);
    chk("t3_valid_abort", n_valid - v0, 0);
    send(8'hA5);
    send(8'h07);
    send(8'h08);
    chk("t3_fe", n_fe - fe0, 1);
    chk("t3_last", last_got(), 16'h0807);
    check_pkts("t3");

    // backpressure and overrun
    snap();
    arr_ready = 1'b0;
    send(8'hA5);
    send(8'h10);
    send(8'h20);
    chk("t4_valid", arr_valid, 1);
    chk("t4_data", arr_data, 16'h2010);
    send(8'h55);
    chk("t4_ov", n_ov - ov0, 1);
    chk("t4_valid_hold", arr_valid, 1);
    chk("t4_data_hold", arr_data, 16'h2010);
    arr_ready = 1'b1;
    cyc(1);
    chk("t4_valid_drop", arr_valid, 0);
    check_pkts("t4");

    // short glitch must not start a frame
    snap();
    RXD = 1'b0;
    cyc(1);
    RXD = 1'b1;
    cyc(6);
    chk("t5_busy", busy, 0);
    send(8'hA5);
    send(8'h5A);
    send(8'hE1);
    chk("t5_fe", n_fe - fe0, 0);
    chk("t5_last", last_got(), 16'hE15A);
    check_pkts("t5");

    // reset during data bit 3 of a payload byte
    send(8'hA5);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    cyc(2);
    RESET = 1'b0;
    #1;
    chk("t6_valid", arr_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_data", arr_data, 0);
    chk("t6_flags", {frame_err, overrun}, 0);
    RXD = 1'b1;
    cyc(3);
    RESET = 1'b1;
    m_load = 0;
    cyc(4);
    snap();
    send(8'hA5);
    send(8'hAA);
    send(8'hBB);
    chk("t6_last", last_got(), 16'hBBAA);
    chk("t6_fe", n_fe - fe0, 0);
    check_pkts("t6");

    // random stream against the model
    snap();
    m_fe = 0;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      bit ok;
      b = ($urandom_range(0, 2) == 0) ? SYNC : 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 9) != 0);
      send(b, ok);
    end
    chk("rnd_fe", n_fe - fe0, m_fe);
    chk("rnd_ov", n_ov - ov0, 0);
    check_pkts("rnd");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
